// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one byte
// on device clock falls, then sample the device ACK and wait for bus release.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack,
    output logic       tx_timeout
);

    localparam int unsigned FL_W  = $clog2(FILTER_LEN + 1);
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_WAIT_REL
    } state_t;

    // index 0 = clock line, index 1 = data line
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_filt;
    logic [FL_W-1:0] r_fcnt [2];
    logic            r_clk_prev;
    logic            w_fall;

    state_t           r_state, w_state_n;
    logic [7:0]       r_byte, w_byte_n;
    logic             r_par, w_par_n;
    logic             r_drv, w_drv_n;
    logic             r_ack, w_ack_n;
    logic [3:0]       r_edge, w_edge_n;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_n;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt_n;
    logic             w_done;
    logic             w_timeout;
    logic             w_to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_filt     <= '1;
            r_fcnt[0]  <= '0;
            r_fcnt[1]  <= '0;
            r_clk_prev <= 1'b1;
        end else begin
            r_sync1    <= {ps2_data, ps2_clk};
            r_sync2    <= r_sync1;
            r_clk_prev <= r_filt[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FL_W'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FL_W'(1);
                end
            end
        end
    end

    assign w_fall = r_clk_prev & ~r_filt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_byte    <= '0;
            r_par     <= 1'b0;
            r_drv     <= 1'b0;
            r_ack     <= 1'b0;
            r_edge    <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_n;
            r_byte    <= w_byte_n;
            r_par     <= w_par_n;
            r_drv     <= w_drv_n;
            r_ack     <= w_ack_n;
            r_edge    <= w_edge_n;
            r_inh_cnt <= w_inh_cnt_n;
            r_to_cnt  <= w_to_cnt_n;
        end
    end

    // A fall on the terminal-count cycle wins over the timeout.
    assign w_to_hit = ~w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_n   = r_state;
        w_byte_n    = r_byte;
        w_par_n     = r_par;
        w_drv_n     = r_drv;
        w_ack_n     = r_ack;
        w_edge_n    = r_edge;
        w_inh_cnt_n = r_inh_cnt;
        w_to_cnt_n  = r_to_cnt;
        w_done      = 1'b0;
        w_timeout   = 1'b0;

        if (r_state == S_SHIFT || r_state == S_WAIT_REL) begin
            if (w_fall) begin
                w_to_cnt_n = '0;
            end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                w_to_cnt_n = r_to_cnt + TO_W'(1);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_byte_n    = tx_data;
                    w_par_n     = ~^tx_data;
                    w_inh_cnt_n = '0;
                    w_state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    w_state_n = S_RTS;
                end else begin
                    w_inh_cnt_n = r_inh_cnt + INH_W'(1);
                end
            end
            S_RTS: begin
                w_state_n  = S_SHIFT;
                w_to_cnt_n = '0;
                w_edge_n   = '0;
                w_drv_n    = 1'b0;
            end
            S_SHIFT: begin
                if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_state_n = S_IDLE;
                end else if (w_fall) begin
                    w_edge_n = r_edge + 4'd1;
                    if (r_edge < 4'd8) begin
                        w_drv_n = r_byte[r_edge[2:0]];
                    end else if (r_edge == 4'd8) begin
                        w_drv_n = r_par;
                    end else if (r_edge == 4'd9) begin
                        w_drv_n = 1'b1;
                    end else begin
                        w_ack_n   = ~r_filt[1];
                        w_state_n = S_WAIT_REL;
                    end
                end
            end
            S_WAIT_REL: begin
                if (r_filt[0] && r_filt[1]) begin
                    w_done    = 1'b1;
                    w_state_n = S_IDLE;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_RTS);
    assign ps2_data_oe = (r_state == S_RTS) || ((r_state == S_SHIFT) && ~r_drv);
    assign tx_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign tx_done     = w_done;
    assign tx_ack      = w_done & r_ack;
    assign tx_timeout  = w_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host; expected wire bits and frame outcomes are queued at send time.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int FILT = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_pin;
    logic       ps2_data_pin;
    logic       clk_oe, data_oe;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_ack, tx_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int n_done_pulses = 0;
    int n_to_pulses = 0;

    logic exp_bits[$];
    int   exp_out[$];   // 0 = timeout, 1 = done without ack, 2 = done with ack

    assign ps2_clk_pin  = dev_clk & ~clk_oe;
    assign ps2_data_pin = dev_data & ~data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk_pin),
        .ps2_data   (ps2_data_pin),
        .ps2_clk_oe (clk_oe),
        .ps2_data_oe(data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_ack     (tx_ack),
        .tx_timeout (tx_timeout)
    );

    always @(posedge clk) begin
        if (tx_done)    n_done_pulses <= n_done_pulses + 1;
        if (tx_timeout) n_to_pulses   <= n_to_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int outcome);
        @(negedge clk);
        check("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        exp_bits.push_back(~^b);
        exp_bits.push_back(1'b1);
        if (outcome >= 0) exp_out.push_back(outcome);
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    // Returns at the negedge sampling the RTS cycle; counts clock-held-low cycles.
    task automatic wait_rts(input bit poke);
        int  low_cnt = 0;
        bit  found = 0;
        bit  data_early = 0;
        for (int i = 0; i < INH + 50; i++) begin
            if (poke && i == 2) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
            end
            if (poke && i == 5) tx_valid = 1'b0;
            if (clk_oe) low_cnt++;
            if (clk_oe && data_oe) begin
                found = 1;
                break;
            end
            if (data_oe) data_early = 1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("rts_seen", found, 1);
        check("data_released_in_inhibit", data_early, 0);
        check("clk_low_cycles", low_cnt, INH + 1);
    endtask

    task automatic sample_bit(input int k);
        logic e;
        if (k > 10) return;
        e = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
        check($sformatf("wire_bit_%0d", k), ps2_data_pin, e);
    endtask

    task automatic dev_edges(input int n, input bit ack, input bit glitch);
        @(negedge clk);
        check("clk_released_in_shift", clk_oe, 0);
        check("start_bit", ps2_data_pin, 0);
        cycles(HALF);
        for (int k = 1; k <= n; k++) begin
            dev_clk = 1'b0;
            if (glitch && k == 3) begin
                cycles(HALF / 2);
                dev_clk = 1'b1;
                cycles(3);
                dev_clk = 1'b0;
                cycles(HALF / 2 - 4);
            end else begin
                cycles(HALF - 1);
            end
            sample_bit(k);
            @(negedge clk);
            dev_clk = 1'b1;
            if (k == n) begin
                if (ack && n == 11) begin
                    cycles(HALF / 2);
                    dev_data = 1'b1;
                end
            end else if (glitch && k == 4) begin
                cycles(HALF / 2);
                dev_clk = 1'b0;
                cycles(3);
                dev_clk = 1'b1;
                cycles(HALF / 2 - 3);
            end else if (ack && k == 10) begin
                cycles(HALF / 2);
                dev_data = 1'b0;
                cycles(HALF / 2);
            end else begin
                cycles(HALF);
            end
        end
    endtask

    task automatic wait_end();
        bit seen = 0;
        int e;
        int obs;
        for (int i = 0; i < 2000; i++) begin
            if (tx_done || tx_timeout) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        e   = (exp_out.size() > 0) ? exp_out.pop_front() : -1;
        obs = !seen ? -2 : (tx_timeout ? 0 : (tx_ack ? 2 : 1));
        check("frame_outcome", obs, e);
        @(negedge clk);
        check("ready_after_end", tx_ready, 1);
        check("oe_after_end", {clk_oe, data_oe}, 2'b00);
    endtask

    initial begin
        int k;
        int pd, pt;
        cycles(3);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe", {clk_oe, data_oe}, 2'b00);
        check("rst_pulses", {tx_done, tx_ack, tx_timeout}, 3'b000);
        rst_n = 1'b1;
        cycles(20);

        // 0xF4 with ACK; tx_valid/tx_data poked during INHIBIT must be ignored
        send(8'hF4, 2);
        wait_rts(1);
        dev_edges(11, 1, 0);
        wait_end();

        // 0xED, device does not ACK
        send(8'hED, 1);
        wait_rts(0);
        dev_edges(11, 0, 0);
        wait_end();

        // 0x00, device never clocks: pulse cycle starts TO clocks after leaving RTS
        send(8'h00, 0);
        wait_rts(0);
        k = 0;
        for (int i = 0; i < TO + 100; i++) begin
            @(negedge clk);
            k++;
            if (tx_timeout) break;
        end
        check("timeout_seen", tx_timeout, 1);
        check("timeout_no_done", tx_done, 0);
        check("timeout_latency", k, TO + 1);
        check("timeout_outcome", 0, exp_out.pop_front());
        @(negedge clk);
        check("ready_after_timeout", tx_ready, 1);
        check("oe_after_timeout", {clk_oe, data_oe}, 2'b00);
        exp_bits.delete();

        // device stops after edge 5, then a back-to-back 0x01 completes
        send(8'h3C, 0);
        wait_rts(0);
        dev_edges(5, 0, 0);
        wait_end();
        exp_bits.delete();
        send(8'h01, 2);
        wait_rts(0);
        dev_edges(11, 1, 0);
        wait_end();

        // 3-cycle clock glitches in both phases must not add edges
        send(8'hA7, 2);
        wait_rts(0);
        dev_edges(11, 1, 1);
        wait_end();

        // reset mid-SHIFT while data is pulled low
        send(8'h00, -1);
        wait_rts(0);
        dev_edges(4, 0, 0);
        cycles(5);
        check("data_low_before_reset", data_oe, 1);
        pd = n_done_pulses;
        pt = n_to_pulses;
        rst_n = 1'b0;
        #1;
        check("reset_oe", {clk_oe, data_oe}, 2'b00);
        check("reset_busy", busy, 0);
        check("reset_ready", tx_ready, 1);
        cycles(5);
        rst_n = 1'b1;
        cycles(1000);
        check("no_done_after_reset", n_done_pulses, pd);
        check("no_timeout_after_reset", n_to_pulses, pt);
        check("idle_after_reset", {busy, clk_oe, data_oe}, 3'b000);
        exp_bits.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
